maria_dll_walker: RTL

// - Display-List-List walker for MARIA.
// - Consumes the DLL base pointer (ZP), the DMA-enable field of CTRL and the

---
 rtl/maria_pkg.sv | 25 ++
 rtl/maria_dll_walker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/maria_pkg.sv
// Shared types for the MARIA display-list-list walker: DLL entry layout,
// walker states and the fixed entry size.
package maria_pkg;

    localparam int DLL_ENTRY_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F0    = 3'd1,
        F1    = 3'd2,
        F2    = 3'd3,
        READY = 3'd4
    } dll_state_e;

    typedef struct packed {
        logic       dli;
        logic       h16;
        logic       h8;
        logic       rsvd;
        logic [3:0] offset;
        logic [7:0] dlh;
        logic [7:0] dll;
    } dll_entry_t;

endpackage

// File: rtl/maria_dll_walker.sv
// Walks the MARIA display-list-list: fetches 3-byte entries, counts zone lines
// down per scanline and raises the DLI request on the last line of a zone.
module maria_dll_walker
    import maria_pkg::*;
(
    input  logic        sysclock,
    input  logic        reset_b,
    input  logic [15:0] ZP,
    input  logic        dma_en,
    input  logic        frame_start,
    input  logic        line_start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] dl_ptr,
    output logic [3:0]  dl_offset,
    output logic [1:0]  holey,
    output logic        dl_valid,
    output logic        nmi_req,
    output logic        busy
);

    dll_state_e  state_q, state_d;
    logic [15:0] dll_ptr_q, dll_ptr_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  dlh_q, dlh_d;
    logic [15:0] dl_ptr_q, dl_ptr_d;
    logic [1:0]  holey_q, holey_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dli_q, dli_d;
    logic        dl_valid_q, dl_valid_d;
    logic        pending_q, pending_d;
    logic        restart_q, restart_d;
    logic        abort_q, abort_d;
    logic [15:0] restart_zp_q, restart_zp_d;

    dll_entry_t  entry_w;
    logic        fs_w;
    logic        ls_w;
    logic        unused_rsvd;

    assign entry_w     = {hdr_q, dlh_q, mem_data};
    assign unused_rsvd = entry_w.rsvd;
    assign fs_w        = frame_start & dma_en;
    assign ls_w        = (line_start | pending_q) & dma_en;

    assign busy      = (state_q == F0) || (state_q == F1) || (state_q == F2);
    assign mem_req   = busy;
    assign mem_addr  = busy ? dll_ptr_q : 16'h0000;
    assign dl_ptr    = dl_ptr_q;
    assign dl_offset = cnt_q;
    assign holey     = holey_q;
    assign dl_valid  = dl_valid_q;
    // DLI is taken from the entry still on screen, before any reload starts.
    assign nmi_req   = (state_q == READY) && !fs_w && ls_w && (cnt_q == 4'd0)
                       && dli_q && dl_valid_q;

    always_comb begin
        state_d      = state_q;
        dll_ptr_d    = dll_ptr_q;
        hdr_d        = hdr_q;
        dlh_d        = dlh_q;
        dl_ptr_d     = dl_ptr_q;
        holey_d      = holey_q;
        cnt_d        = cnt_q;
        dli_d        = dli_q;
        dl_valid_d   = dl_valid_q;
        pending_d    = pending_q;
        restart_d    = restart_q;
        abort_d      = abort_q;
        restart_zp_d = restart_zp_q;

        case (state_q)
            IDLE: begin
                if (fs_w) begin
                    dll_ptr_d  = ZP;
                    dl_valid_d = 1'b0;
                    pending_d  = 1'b0;
                    state_d    = F0;
                end
            end
            F0, F1, F2: begin
                // The bus request is never withdrawn: restart/abort only
                // take effect once the outstanding read is acknowledged.
                if (fs_w) begin
                    restart_d    = 1'b1;
                    restart_zp_d = ZP;
                    abort_d      = 1'b0;
                    pending_d    = 1'b0;
                end else if (!dma_en) begin
                    abort_d   = 1'b1;
                    restart_d = 1'b0;
                    pending_d = 1'b0;
                end else if (line_start) begin
                    pending_d = 1'b1;
                end

                if (mem_ack) begin
                    if (abort_d) begin
                        state_d    = IDLE;
                        dl_valid_d = 1'b0;
                        pending_d  = 1'b0;
                    end else if (restart_d) begin
                        dll_ptr_d = restart_zp_d;
                        state_d   = F0;
                    end else begin
                        dll_ptr_d = dll_ptr_q + 16'd1;
                        if (state_q == F0) begin
                            hdr_d   = mem_data;
                            state_d = F1;
                        end else if (state_q == F1) begin
                            dlh_d   = mem_data;
                            state_d = F2;
                        end else begin
                            dl_ptr_d   = {entry_w.dlh, entry_w.dll};
                            holey_d    = {entry_w.h16, entry_w.h8};
                            cnt_d      = entry_w.offset;
                            dli_d      = entry_w.dli;
                            dl_valid_d = 1'b1;
                            state_d    = READY;
                        end
                    end
                    abort_d   = 1'b0;
                    restart_d = 1'b0;
                end
            end
            READY: begin
                if (fs_w) begin
                    dll_ptr_d  = ZP;
                    dl_valid_d = 1'b0;
                    pending_d  = 1'b0;
                    state_d    = F0;
                end else if (ls_w) begin
                    pending_d = 1'b0;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        dl_valid_d = 1'b0;
                        state_d    = F0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclock or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= IDLE;
            dll_ptr_q    <= 16'h0000;
            hdr_q        <= 8'h00;
            dlh_q        <= 8'h00;
            dl_ptr_q     <= 16'h0000;
            holey_q      <= 2'b00;
            cnt_q        <= 4'd0;
            dli_q        <= 1'b0;
            dl_valid_q   <= 1'b0;
            pending_q    <= 1'b0;
            restart_q    <= 1'b0;
            abort_q      <= 1'b0;
            restart_zp_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            dll_ptr_q    <= dll_ptr_d;
            hdr_q        <= hdr_d;
            dlh_q        <= dlh_d;
            dl_ptr_q     <= dl_ptr_d;
            holey_q      <= holey_d;
            cnt_q        <= cnt_d;
            dli_q        <= dli_d;
            dl_valid_q   <= dl_valid_d;
            pending_q    <= pending_d;
            restart_q    <= restart_d;
            abort_q      <= abort_d;
            restart_zp_q <= restart_zp_d;
        end
    end

endmodule
